packetizer_gen2: RTL and testbench

PACKETIZER_GEN2 -- requirements
Module: packetizer_gen2

---
 rtl/packetizer_pkg.sv | 15 +
 rtl/axis_skid_buf.sv | 50 +++++
 rtl/packetizer_gen2.sv | 115 +++++++++++
 tb/tb_packetizer_gen2.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packetizer_pkg.sv
// Shared definitions for the packetizer: FSM state encoding and header field layout.
// Header layout is only used when PACKETIZER_HEADER_EN is defined.
package packetizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    // Header beat: {len_q, pkt_count[15:0]}, count in the low half.
    localparam int HDR_CNT_LSB = 0;
    localparam int HDR_LEN_LSB = 16;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered outputs, full throughput, and an
// upstream ready that comes only from a flop.
module axis_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] i_s_data,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_m_valid,
    input  logic             i_m_ready
);

    logic [WIDTH-1:0] r_m_data;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_sk_data;
    logic             r_sk_valid;
    logic             w_in_fire;

    assign o_s_ready = ~r_sk_valid;
    assign w_in_fire = i_s_valid & ~r_sk_valid;
    assign o_m_data  = r_m_data;
    assign o_m_valid = r_m_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_sk_data  <= '0;
            r_sk_valid <= 1'b0;
        end else if (!r_m_valid || i_m_ready) begin
            // Output slot frees up: drain the skid entry first to keep order.
            if (r_sk_valid) begin
                r_m_data   <= r_sk_data;
                r_m_valid  <= 1'b1;
                r_sk_valid <= 1'b0;
            end else begin
                r_m_valid <= w_in_fire;
                if (w_in_fire)
                    r_m_data <= i_s_data;
            end
        end else if (w_in_fire) begin
            r_sk_data  <= i_s_data;
            r_sk_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/packetizer_gen2.sv
// Cuts a continuous sample stream into cfg_len-beat packets with tlast for an S2MM DMA.
// Optional header beat per packet when PACKETIZER_HEADER_EN is defined.
module packetizer_gen2
    import packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  last,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic [LEN_WIDTH-1:0]  beat_count,
    output logic [31:0]           pkt_count,
    output logic                  busy
);

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_len_q;
    logic [LEN_WIDTH-1:0]  r_beat_count;
    logic [31:0]           r_pkt_count;

    logic                  w_skid_ready;
    logic                  w_in_valid;
    logic [DATA_WIDTH:0]   w_in_data;
    logic [DATA_WIDTH:0]   w_out_data;
    logic [LEN_WIDTH-1:0]  w_beat_next;
    logic                  w_data_tlast;
    logic                  w_s_hs;

    assign s_axis_tready = (r_state == ST_DATA) & w_skid_ready;
    assign w_s_hs        = s_axis_tvalid & s_axis_tready;
    assign w_beat_next   = r_beat_count + LEN_WIDTH'(1);
    // len_q is never 0 in DATA, so the next count cannot wrap before it matches.
    assign w_data_tlast  = (w_beat_next == r_len_q);

`ifdef PACKETIZER_HEADER_EN
    logic [DATA_WIDTH+LEN_WIDTH+HDR_LEN_LSB-HDR_CNT_LSB-1:0] w_hdr_ext;

    assign w_hdr_ext  = {{DATA_WIDTH{1'b0}}, r_len_q, r_pkt_count[HDR_LEN_LSB-1:HDR_CNT_LSB]};
    assign w_in_valid = (r_state == ST_HDR) | (s_axis_tvalid & (r_state == ST_DATA));
    assign w_in_data  = (r_state == ST_HDR) ? {1'b0, w_hdr_ext[DATA_WIDTH-1:0]}
                                            : {w_data_tlast, s_axis_tdata};
`else
    assign w_in_valid = s_axis_tvalid & (r_state == ST_DATA);
    assign w_in_data  = {w_data_tlast, s_axis_tdata};
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_len_q      <= '0;
            r_beat_count <= '0;
            r_pkt_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_len != '0) begin
                        r_len_q      <= cfg_len;
                        r_beat_count <= '0;
`ifdef PACKETIZER_HEADER_EN
                        r_state      <= ST_HDR;
`else
                        r_state      <= ST_DATA;
`endif
                    end
                end
`ifdef PACKETIZER_HEADER_EN
                ST_HDR: begin
                    if (w_skid_ready)
                        r_state <= ST_DATA;
                end
`endif
                ST_DATA: begin
                    if (w_s_hs) begin
                        r_beat_count <= w_beat_next;
                        if (w_data_tlast) begin
                            r_pkt_count <= r_pkt_count + 32'd1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_s_data  (w_in_data),
        .i_s_valid (w_in_valid),
        .o_s_ready (w_skid_ready),
        .o_m_data  (w_out_data),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready)
    );

    assign m_axis_tdata = w_out_data[DATA_WIDTH-1:0];
    assign m_axis_tlast = w_out_data[DATA_WIDTH];
    assign last         = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign beat_count   = r_beat_count;
    assign pkt_count    = r_pkt_count;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_packetizer_gen2.sv
// Directed bench for packetizer_gen2 (LEN_WIDTH reduced to 8 so the max-length case is short).
module tb_packetizer_gen2;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          last;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] beat_count;
    logic [31:0]   pkt_count;
    logic          busy;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            in_cnt   = 0;
    int            last_cnt = 0;
    logic          hs;
    logic [DW:0]   q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always #5 aclk = ~aclk;

    packetizer_gen2 #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .last          (last),
        .cfg_len       (cfg_len),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects accepted beats and checks hold-while-stalled.
    always @(posedge aclk) begin
        if (aresetn) begin
            if (prev_stall) begin
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready)
                q.push_back({m_tlast, m_tdata});
            if (last)
                last_cnt <= last_cnt + 1;
            prev_stall <= m_tvalid && !m_tready;
            prev_data  <= m_tdata;
            prev_last  <= m_tlast;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic step();
        hs = s_tvalid && s_tready;
        @(posedge aclk);
        #1;
        if (hs) begin
            in_cnt++;
            s_tdata = s_tdata + 1;
        end
    endtask

    task automatic run_to(input int n, input int budget, input bit toggle, output int cyc);
        cyc = 0;
        while (in_cnt < n && cyc < budget) begin
            if (toggle) m_tready = ~m_tready;
            step();
            cyc++;
        end
        chk("beats_in", in_cnt, n);
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        cfg_len  = '0;
        m_tready = 1'b1;
        step();
        step();
        aresetn  = 1'b1;
        q.delete();
        last_cnt = 0;
        in_cnt   = 0;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        cfg_len  = '0;
        m_tready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        int cyc;
        int tl;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        cfg_len  = '0;
        aresetn  = 1'b0;
        step();
        step();
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tlast",  32'(m_tlast), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_last",     32'(last), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_beat_cnt", 32'(beat_count), 0);
        chk("rst_pkt_cnt",  pkt_count, 0);
        do_reset();

`ifdef PACKETIZER_HEADER_EN
        // Header build: cfg_len=2, two packets.
        s_tdata  = 32'hA0;
        cfg_len  = 8'd2;
        s_tvalid = 1'b1;
        run_to(4, 40, 1'b0, cyc);
        drain();
        chk("hdr_qsize", q.size(), 6);
        if (q.size() == 6) begin
            chk("hdr0_data", q[0][31:0], 32'h0002_0000);  chk("hdr0_last", 32'(q[0][32]), 0);
            chk("d0_data",   q[1][31:0], 32'hA0);         chk("d0_last",   32'(q[1][32]), 0);
            chk("d1_data",   q[2][31:0], 32'hA1);         chk("d1_last",   32'(q[2][32]), 1);
            chk("hdr1_data", q[3][31:0], 32'h0002_0001);  chk("hdr1_last", 32'(q[3][32]), 0);
            chk("d2_data",   q[4][31:0], 32'hA2);         chk("d2_last",   32'(q[4][32]), 0);
            chk("d3_data",   q[5][31:0], 32'hA3);         chk("d3_last",   32'(q[5][32]), 1);
        end
        chk("hdr_pkt_cnt", pkt_count, 2);
        chk("hdr_last_cnt", last_cnt, 2);
`else
        // cfg_len=0 holds the block off; enabling gives first output two cycles later.
        s_tdata  = 32'h55;
        s_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("dis_s_tready", 32'(s_tready), 0);
            chk("dis_m_tvalid", 32'(m_tvalid), 0);
        end
        cfg_len = 8'd2;
        step();
        chk("en1_m_tvalid", 32'(m_tvalid), 0);
        chk("en1_s_tready", 32'(s_tready), 1);
        step();
        chk("en2_m_tvalid", 32'(m_tvalid), 1);
        chk("en2_m_tdata",  m_tdata, 32'h55);
        do_reset();

        // cfg_len=4, continuous traffic, 3 packets, one latch cycle between packets.
        s_tdata  = 32'h100;
        cfg_len  = 8'd4;
        s_tvalid = 1'b1;
        run_to(12, 100, 1'b0, cyc);
        chk("len4_cycles", cyc, 15);
        drain();
        chk("len4_qsize", q.size(), 12);
        for (int i = 0; i < 12 && i < q.size(); i++) begin
            chk("len4_data", q[i][31:0], 32'h100 + i);
            chk("len4_last", 32'(q[i][32]), 32'((i % 4) == 3));
        end
        chk("len4_last_pulses", last_cnt, 3);
        chk("len4_pkt_cnt", pkt_count, 3);
        chk("len4_busy", 32'(busy), 0);
        do_reset();

        // cfg_len=3 with m_tready toggling: order, no loss, no duplicates.
        s_tdata  = 32'h200;
        cfg_len  = 8'd3;
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        run_to(9, 200, 1'b1, cyc);
        drain();
        chk("bp_qsize", q.size(), 9);
        for (int i = 0; i < 9 && i < q.size(); i++) begin
            chk("bp_data", q[i][31:0], 32'h200 + i);
            chk("bp_last", 32'(q[i][32]), 32'((i % 3) == 2));
        end
        chk("bp_last_pulses", last_cnt, 3);
        chk("bp_pkt_cnt", pkt_count, 3);
        do_reset();

        // cfg_len 5 -> 2 mid-packet: takes effect on the following packet.
        s_tdata  = 32'h300;
        cfg_len  = 8'd5;
        s_tvalid = 1'b1;
        run_to(3, 50, 1'b0, cyc);
        cfg_len = 8'd2;
        run_to(7, 50, 1'b0, cyc);
        drain();
        chk("chg_qsize", q.size(), 7);
        for (int i = 0; i < 7 && i < q.size(); i++)
            chk("chg_last", 32'(q[i][32]), 32'(i == 4 || i == 6));
        chk("chg_pkt_cnt", pkt_count, 2);
        do_reset();

        // Reset after beat 2 of the second cfg_len=4 packet discards it.
        s_tdata  = 32'h400;
        cfg_len  = 8'd4;
        s_tvalid = 1'b1;
        run_to(6, 50, 1'b0, cyc);
        chk("pre_rst_beat_cnt", 32'(beat_count), 2);
        chk("pre_rst_pkt_cnt", pkt_count, 1);
        chk("pre_rst_busy", 32'(busy), 1);
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        step();
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 0);
        chk("mid_rst_s_tready", 32'(s_tready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pkt_cnt", pkt_count, 0);
        chk("mid_rst_qsize", q.size(), 5);
        tl = 0;
        foreach (q[i]) if (q[i][32]) tl++;
        chk("mid_rst_tlasts", tl, 1);
        aresetn  = 1'b1;
        q.delete();
        last_cnt = 0;
        in_cnt   = 0;
        s_tdata  = 32'h500;
        s_tvalid = 1'b1;
        step();
        chk("post_rst_beat_cnt", 32'(beat_count), 0);
        chk("post_rst_pkt_cnt", pkt_count, 0);
        chk("post_rst_busy", 32'(busy), 1);
        run_to(4, 50, 1'b0, cyc);
        drain();
        chk("post_rst_qsize", q.size(), 4);
        if (q.size() == 4) begin
            chk("post_rst_d0", q[0][31:0], 32'h500);
            chk("post_rst_last3", 32'(q[3][32]), 1);
        end
        chk("post_rst_pulses", last_cnt, 1);
        chk("post_rst_pkt_cnt2", pkt_count, 1);
        do_reset();

        // cfg_len=1: every beat is a tlast beat.
        s_tdata  = 32'h600;
        cfg_len  = 8'd1;
        s_tvalid = 1'b1;
        run_to(3, 30, 1'b0, cyc);
        chk("len1_cycles", cyc, 6);
        drain();
        chk("len1_qsize", q.size(), 3);
        foreach (q[i]) chk("len1_last", 32'(q[i][32]), 1);
        chk("len1_pulses", last_cnt, 3);
        do_reset();

        // Maximum length: tlast on beat 255, counter stops at 255.
        s_tdata  = 32'h0;
        cfg_len  = 8'hFF;
        s_tvalid = 1'b1;
        run_to(255, 400, 1'b0, cyc);
        cfg_len  = '0;
        s_tvalid = 1'b0;
        chk("max_beat_cnt", 32'(beat_count), 255);
        chk("max_busy", 32'(busy), 0);
        drain();
        chk("max_qsize", q.size(), 255);
        tl = 0;
        foreach (q[i]) if (q[i][32]) tl++;
        chk("max_tlasts", tl, 1);
        if (q.size() == 255)
            chk("max_last_on_final", 32'(q[254][32]), 1);
        chk("max_pkt_cnt", pkt_count, 1);
        chk("max_beat_cnt_hold", 32'(beat_count), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
